// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: controller state encoding
// and the level of an idle serial line.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } uart_state_t;

  localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/shift_register_l.sv
// Serial-in parallel-out shift register with load (shift) enable.
// Mode 1 shifts right with the new bit entering the MSB; Mode 0 shifts left.
module shift_register_l #(
  parameter int W    = 8,
  parameter int Mode = 0
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         load,
  input  logic         in,
  output logic [W-1:0] q
);

  generate
    if (W == 1) begin : g_single
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)  q <= '0;
        else if (load) q <= in;
      end
    end else if (Mode == 1) begin : g_right
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)  q <= '0;
        else if (load) q <= {in, q[W-1:1]};
      end
    end else begin : g_left
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)  q <= '0;
        else if (load) q <= {q[W-2:0], in};
      end
    end
  endgenerate

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: synchronizes rx, times bit cells with a divider,
// pulses the shift register at mid-bit and strobes a good word or frame error.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int W   = 8,
  parameter int DIV = 16
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         rx,
  output logic [W-1:0] data,
  output logic         valid,
  output logic         frame_err,
  output logic         busy
);

  localparam int CW = $clog2(DIV);
  localparam int BW = $clog2(W + 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [BW-1:0] BI_LAST  = BW'(W - 1);

  logic        rx_m, rx_s;
  uart_state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [BW-1:0] bi;
  logic          shift_en, take, err;
  logic [W-1:0]  sr_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_m <= LINE_IDLE;
      rx_s <= LINE_IDLE;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    shift_en = 1'b0;
    take     = 1'b0;
    err      = 1'b0;
    case (state)
      IDLE:  if (rx_s != LINE_IDLE) state_nx = START;
      START: if (cnt == CNT_HALF) state_nx = rx_s ? IDLE : DATA;
      DATA: begin
        if (cnt == CNT_LAST) begin
          shift_en = 1'b1;
          if (bi == BI_LAST) state_nx = STOP;
        end
      end
      STOP: begin
        if (cnt == CNT_LAST) begin
          if (rx_s) begin
            take     = 1'b1;
            state_nx = IDLE;
          end else begin
            err      = 1'b1;
            state_nx = BREAK;
          end
        end
      end
      // Hold off new starts until the line has gone back to idle.
      BREAK:   if (rx_s == LINE_IDLE) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Divider restarts on every state change and after each data-bit cell.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                                cnt <= '0;
    else if (state_nx != state)                  cnt <= '0;
    else if (state == DATA && cnt == CNT_LAST)   cnt <= '0;
    else                                         cnt <= cnt + 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)          bi <= '0;
    else if (state == START) bi <= '0;
    else if (shift_en)     bi <= bi + 1'b1;
  end

  shift_register_l #(.W(W), .Mode(1)) u_sr (
    .clock   (clock),
    .reset_n (reset_n),
    .load    (shift_en),
    .in      (rx_s),
    .q       (sr_q)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      valid     <= take;
      frame_err <= err;
      if (take) data <= sr_q;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: frames are generated at bit level and the expected
// strobe times, busy windows and received words come from frame timing arithmetic.
module tb_uart_rx_ctrl;

  localparam int W    = 8;
  localparam int DIV  = 16;
  localparam int MAXC = 16384;
  localparam int LAT  = 2 + 1 + DIV / 2 + W * DIV + DIV;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         rx = 1'b1;
  logic [W-1:0] data;
  logic         valid, frame_err, busy;

  uart_rx_ctrl #(.W(W), .DIV(DIV)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .rx        (rx),
    .data      (data),
    .valid     (valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  // ---------------- clock / cycle count ----------------
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  bit           exp_v    [MAXC];
  bit           exp_f    [MAXC];
  bit           exp_busy [MAXC];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] model_data = '0;
  int           seen_v_cyc[$];
  logic [W-1:0] seen_v_data[$];
  int           n_ferr = 0;
  int           n_chk = 0;
  int           n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clock) begin
    if (cyc < MAXC) begin
      if (!reset_n) model_data = '0;
      else if (exp_v[cyc] && exp_q.size() > 0) model_data = exp_q.pop_front();
      chk("valid", {31'd0, valid}, {31'd0, exp_v[cyc] & reset_n});
      chk("frame_err", {31'd0, frame_err}, {31'd0, exp_f[cyc] & reset_n});
      chk("busy", {31'd0, busy}, {31'd0, exp_busy[cyc] & reset_n});
      chk("data", {24'd0, data}, {24'd0, model_data});
    end
    if (valid) begin
      seen_v_cyc.push_back(cyc);
      seen_v_data.push_back(data);
    end
    if (frame_err) n_ferr++;
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic set_busy(input int a, input int b);
    for (int c = a; c <= b; c++) if (c < MAXC) exp_busy[c] = 1'b1;
  endtask

  // Drives one frame; the line changes right after edge t0, so the first
  // synchronizer flop sees the start bit one edge later.
  task automatic send_frame(input logic [W-1:0] d, input bit stop_val,
                            input int stop_len, output int t0);
    t0 = cyc;
    if (stop_val) begin
      set_busy(t0 + 3, t0 + LAT - 1);
      if (t0 + LAT < MAXC) exp_v[t0 + LAT] = 1'b1;
      exp_q.push_back(d);
    end else begin
      if (t0 + LAT < MAXC) exp_f[t0 + LAT] = 1'b1;
      set_busy(t0 + 3, t0 + (W + 1) * DIV + stop_len + 2);
    end
    rx = 1'b0;
    tick(DIV);
    for (int i = 0; i < W; i++) begin
      rx = d[i];
      tick(DIV);
    end
    rx = stop_val;
    tick(stop_len);
    rx = 1'b1;
  endtask

  task automatic do_reset(input int hold);
    for (int c = cyc; c < cyc + 400 && c < MAXC; c++) begin
      exp_v[c] = 1'b0;
      exp_f[c] = 1'b0;
      exp_busy[c] = 1'b0;
    end
    exp_q.delete();
    reset_n = 1'b0;
    rx = 1'b1;
    #1;
    chk("async_rst_busy", {31'd0, busy}, 32'd0);
    chk("async_rst_data", {24'd0, data}, 32'd0);
    chk("async_rst_valid", {31'd0, valid}, 32'd0);
    tick(hold);
    reset_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t0, t1, nf0, gap, len;
    logic [W-1:0] d;

    // 1: reset, then idle line
    tick(3);
    reset_n = 1'b1;
    tick(50);
    chk("idle_no_strobe", seen_v_cyc.size(), 0);

    // 2: single frame 0xA5
    seen_v_cyc.delete(); seen_v_data.delete();
    nf0 = n_ferr;
    send_frame(8'hA5, 1'b1, DIV, t0);
    tick(10);
    chk("a5_count", seen_v_cyc.size(), 1);
    if (seen_v_cyc.size() >= 1) begin
      chk("a5_latency", seen_v_cyc[0] - t0, 155);
      chk("a5_data", {24'd0, seen_v_data[0]}, 32'hA5);
    end
    chk("a5_no_ferr", n_ferr - nf0, 0);

    // 3: back-to-back 0x00 then 0xFF
    seen_v_cyc.delete(); seen_v_data.delete();
    send_frame(8'h00, 1'b1, DIV, t0);
    send_frame(8'hFF, 1'b1, DIV, t1);
    tick(10);
    chk("b2b_count", seen_v_cyc.size(), 2);
    if (seen_v_cyc.size() >= 2) begin
      chk("b2b_spacing", seen_v_cyc[1] - seen_v_cyc[0], 160);
      chk("b2b_data0", {24'd0, seen_v_data[0]}, 32'h00);
      chk("b2b_data1", {24'd0, seen_v_data[1]}, 32'hFF);
    end

    // 4: short glitch
    seen_v_cyc.delete();
    nf0 = n_ferr;
    t0 = cyc;
    set_busy(t0 + 3, t0 + 10);
    rx = 1'b0;
    tick(5);
    rx = 1'b1;
    tick(40);
    chk("glitch_no_valid", seen_v_cyc.size(), 0);
    chk("glitch_no_ferr", n_ferr - nf0, 0);

    // 5: stop held low for 3 bit times, then a good frame
    seen_v_cyc.delete(); seen_v_data.delete();
    nf0 = n_ferr;
    send_frame(8'h3C, 1'b0, 3 * DIV, t0);
    chk("ferr_single", n_ferr - nf0, 1);
    chk("ferr_data_kept", {24'd0, data}, 32'hFF);
    tick(5);
    send_frame(8'h81, 1'b1, DIV, t0);
    tick(5);
    chk("after_ferr_count", seen_v_cyc.size(), 1);
    if (seen_v_cyc.size() >= 1) chk("after_ferr_data", {24'd0, seen_v_data[0]}, 32'h81);

    // 6: reset during data bit 4 of 0x5A
    seen_v_cyc.delete(); seen_v_data.delete();
    d = 8'h5A;
    t0 = cyc;
    set_busy(t0 + 3, t0 + LAT - 1);
    exp_v[t0 + LAT] = 1'b1;
    exp_q.push_back(d);
    rx = 1'b0;
    tick(DIV);
    for (int i = 0; i < 4; i++) begin
      rx = d[i];
      tick(DIV);
    end
    rx = d[4];
    tick(DIV / 2);
    do_reset(4);
    tick(200);
    chk("rst_no_strobe", seen_v_cyc.size(), 0);
    send_frame(8'h5A, 1'b1, DIV, t0);
    tick(5);
    chk("rst_next_count", seen_v_cyc.size(), 1);
    if (seen_v_cyc.size() >= 1) chk("rst_next_data", {24'd0, seen_v_data[0]}, 32'h5A);

    // random frames, gaps and occasional line breaks
    for (int k = 0; k < 14; k++) begin
      d = W'($urandom_range(0, 255));
      if ($urandom_range(0, 4) == 0) begin
        len = $urandom_range(16, 48);
        send_frame(d, 1'b0, len, t0);
        gap = $urandom_range(1, 20);
      end else begin
        send_frame(d, 1'b1, DIV, t0);
        gap = $urandom_range(0, 20);
      end
      if (gap > 0) tick(gap);
    end
    tick(30);
    chk("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
